// File: rtl/coproc_pkg.sv
// Shared definitions for the HPS command bridge: opcodes, instruction field
// positions, FSM states, status bit indices and the timeout error word.
package coproc_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_WRITE  = 3'd1,
    OP_READ   = 3'd2,
    OP_START  = 3'd3,
    OP_STATUS = 3'd4
  } op_e;

  // Instruction word layout (address field sized for a 16-bit address).
  localparam int OP_LSB    = 0;
  localparam int OP_MSB    = 2;
  localparam int ADDR_LSB  = 3;
  localparam int ADDR_MSB  = 18;
  localparam int WDATA_LSB = 19;
  localparam int WDATA_MSB = 26;
  localparam int PARAM_LSB = 27;
  localparam int PARAM_MSB = 31;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Bit positions inside the wait/status word returned to the HPS.
  localparam int WS_BUSY = 0;
  localparam int WS_DONE = 1;

  // Opcodes that actually reach the core; NOP and 5..7 complete locally.
  function automatic logic is_core_op(input logic [2:0] op);
    return (op >= OP_WRITE) && (op <= OP_STATUS);
  endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Saturating response timer: cleared when a command is accepted, counts while
// waiting for the core, flags expiry on the last allowed cycle.
module bridge_timeout_ctr #(
  parameter int TIMEOUT = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise advance until LAST and stick there.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Only meaningful while the bridge is actually waiting on a response.
  assign expired = enable & ~clear & (count_q == LAST);

endmodule

// File: rtl/hps_cmd_bridge.sv
// Bridges HPS PIO handshake (instruction / req+abort / result / busy+done) to
// the image-filter core's valid/ready command and response-strobe interface.
module hps_cmd_bridge
  import coproc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_i,
  input  logic [1:0]        act_ins_i,
  output logic [31:0]       data_o,
  output logic [1:0]        wait_s_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [2:0]        cmd_op_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [7:0]        cmd_wdata_o,
  output logic [4:0]        cmd_param_o,
  input  logic              rsp_valid_i,
  input  logic [31:0]       rsp_data_i,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          wait_s_q, wait_s_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [2:0]          cmd_op_q, cmd_op_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [7:0]          cmd_wdata_q, cmd_wdata_d;
  logic [4:0]          cmd_param_q, cmd_param_d;
  logic                err_q, err_d;

  logic                abort;
  logic                req_rise;
  logic                tmr_clear;
  logic                tmr_enable;
  logic                tmr_expired;

  assign abort    = act_ins_i[1];
  assign req_rise = act_ins_i[0] & ~req_q;

  // Timer restarts on the accepting handshake and only runs in WAIT_RSP.
  assign tmr_clear  = abort | ((state_q == ISSUE) & cmd_ready_i);
  assign tmr_enable = (state_q == WAIT_RSP) & ~abort;

  bridge_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Next-state and next-output logic; abort overrides every FSM transition.
  always_comb begin
    state_d     = state_q;
    req_d       = act_ins_i[0];
    data_d      = data_q;
    wait_s_d    = wait_s_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_param_d = cmd_param_q;
    err_d       = err_q;

    if (abort) begin
      state_d     = IDLE;
      cmd_valid_d = 1'b0;
      wait_s_d    = 2'b00;
      data_d      = '0;
      err_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_rise) begin
            cmd_op_d    = instr_i[OP_MSB:OP_LSB];
            cmd_addr_d  = instr_i[ADDR_LSB +: ADDR_W];
            cmd_wdata_d = instr_i[WDATA_MSB:WDATA_LSB];
            cmd_param_d = instr_i[PARAM_MSB:PARAM_LSB];
            err_d       = 1'b0;
            wait_s_d    = 2'b00;
            if (is_core_op(instr_i[OP_MSB:OP_LSB])) begin
              state_d           = ISSUE;
              cmd_valid_d       = 1'b1;
              wait_s_d[WS_BUSY] = 1'b1;
            end else begin
              // Nothing to send: complete immediately with a zero result.
              state_d           = DONE;
              data_d            = '0;
              wait_s_d[WS_DONE] = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cmd_ready_i) begin
            state_d     = WAIT_RSP;
            cmd_valid_d = 1'b0;
          end
        end
        WAIT_RSP: begin
          // A response arriving on the expiry cycle still counts as success.
          if (rsp_valid_i) begin
            state_d  = DONE;
            data_d   = rsp_data_i;
            wait_s_d = 2'b00;
            wait_s_d[WS_DONE] = 1'b1;
          end else if (tmr_expired) begin
            state_d  = DONE;
            data_d   = ERR_WORD;
            err_d    = 1'b1;
            wait_s_d = 2'b00;
            wait_s_d[WS_DONE] = 1'b1;
          end
        end
        DONE: begin
          if (!act_ins_i[0]) begin
            state_d  = IDLE;
            wait_s_d = 2'b00;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; req_q resets high so a stuck req is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b1;
      data_q      <= '0;
      wait_s_q    <= 2'b00;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_param_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      data_q      <= data_d;
      wait_s_q    <= wait_s_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_param_q <= cmd_param_d;
      err_q       <= err_d;
    end
  end

  assign data_o      = data_q;
  assign wait_s_o    = wait_s_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_op_o    = cmd_op_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_wdata_o = cmd_wdata_q;
  assign cmd_param_o = cmd_param_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hps_cmd_bridge.sv
// Directed bench for hps_cmd_bridge: table of single transactions plus
// hand-written timeout, abort, reset and back-to-back sequences.
module tb_hps_cmd_bridge;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       instr_i;
  logic [1:0]        act_ins_i;
  logic [31:0]       data_o;
  logic [1:0]        wait_s_o;
  logic              cmd_valid_o;
  logic              cmd_ready_i;
  logic [2:0]        cmd_op_o;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic [7:0]        cmd_wdata_o;
  logic [4:0]        cmd_param_o;
  logic              rsp_valid_i;
  logic [31:0]       rsp_data_i;
  logic              err_o;

  hps_cmd_bridge #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_i     (instr_i),
    .act_ins_i   (act_ins_i),
    .data_o      (data_o),
    .wait_s_o    (wait_s_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_op_o    (cmd_op_o),
    .cmd_addr_o  (cmd_addr_o),
    .cmd_wdata_o (cmd_wdata_o),
    .cmd_param_o (cmd_param_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_data_i  (rsp_data_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  // Count every accepted command handshake.
  always @(posedge clk) begin
    if (cmd_valid_o && cmd_ready_i) hs_cnt = hs_cnt + 1;
  end

  typedef struct {
    logic [31:0] instr;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] rsp;
    logic        is_cmd;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [4:0]  param;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full request/complete/release cycle, checked along the way.
  task automatic do_txn(input vec_t v, input string tag);
    int hs0;
    hs0 = hs_cnt;
    instr_i   = v.instr;
    act_ins_i = 2'b01;
    tick();
    if (v.is_cmd) begin
      check({tag, ".valid"}, cmd_valid_o, 1);
      check({tag, ".busy"},  wait_s_o, 2'b01);
      check({tag, ".err_clr"}, err_o, 0);
      for (int i = 0; i < v.rdy_dly; i++) tick();
      check({tag, ".valid_hold"}, cmd_valid_o, 1);
      check({tag, ".op"},    cmd_op_o, v.op);
      check({tag, ".addr"},  cmd_addr_o, v.addr);
      check({tag, ".wdata"}, cmd_wdata_o, v.wdata);
      check({tag, ".param"}, cmd_param_o, v.param);
      cmd_ready_i = 1'b1;
      tick();
      cmd_ready_i = 1'b0;
      check({tag, ".valid_drop"}, cmd_valid_o, 0);
      for (int i = 0; i < v.rsp_dly; i++) tick();
      check({tag, ".wait_busy"}, wait_s_o, 2'b01);
      rsp_valid_i = 1'b1;
      rsp_data_i  = v.rsp;
      tick();
      rsp_valid_i = 1'b0;
      rsp_data_i  = 32'h0;
      check({tag, ".done"}, wait_s_o, 2'b10);
      check({tag, ".data"}, data_o, v.rsp);
      check({tag, ".err"},  err_o, 0);
      check({tag, ".hs_one"}, hs_cnt - hs0, 1);
    end else begin
      check({tag, ".nop_done"}, wait_s_o, 2'b10);
      check({tag, ".nop_data"}, data_o, 0);
      check({tag, ".nop_valid"}, cmd_valid_o, 0);
      tick();
      check({tag, ".nop_hs"}, hs_cnt - hs0, 0);
    end
    act_ins_i = 2'b00;
    tick();
    check({tag, ".release"}, wait_s_o, 2'b00);
    check({tag, ".data_keep"}, data_o, v.is_cmd ? v.rsp : 32'h0);
  endtask

  // READ with no response (timeout) or with a response on the expiry cycle.
  task automatic do_timeout(input logic with_rsp, input string tag);
    instr_i   = {5'd0, 8'd0, 16'h0042, 3'd2};
    act_ins_i = 2'b01;
    tick();
    check({tag, ".valid"}, cmd_valid_o, 1);
    check({tag, ".err_clr"}, err_o, 0);
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check({tag, ".still_busy"}, wait_s_o, 2'b01);
    if (with_rsp) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'h1234_5678;
    end
    tick();
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'h0;
    check({tag, ".done"}, wait_s_o, 2'b10);
    check({tag, ".data"}, data_o, with_rsp ? 32'h1234_5678 : 32'hDEAD_BEEF);
    check({tag, ".err"},  err_o, with_rsp ? 0 : 1);
    act_ins_i = 2'b00;
    tick();
    check({tag, ".release"}, wait_s_o, 2'b00);
    check({tag, ".err_keep"}, err_o, with_rsp ? 0 : 1);
  endtask

  initial begin
    vec_t v;
    int   hs0;

    vecs[0] = '{{5'd3,  8'hA5, 16'h0123, 3'd1}, 3, 2, 32'h0000_0001, 1'b1, 3'd1, 16'h0123, 8'hA5, 5'd3};
    vecs[1] = '{{5'd0,  8'h00, 16'hBEEF, 3'd2}, 0, 0, 32'h0000_00C3, 1'b1, 3'd2, 16'hBEEF, 8'h00, 5'd0};
    vecs[2] = '{{5'd17, 8'h00, 16'h0000, 3'd3}, 1, 5, 32'hCAFE_0001, 1'b1, 3'd3, 16'h0000, 8'h00, 5'd17};
    vecs[3] = '{{5'd31, 8'hFF, 16'hFFFF, 3'd4}, 0, 1, 32'h8000_0000, 1'b1, 3'd4, 16'hFFFF, 8'hFF, 5'd31};
    vecs[4] = '{{5'd2,  8'h11, 16'h2222, 3'd0}, 0, 0, 32'h0,         1'b0, 3'd0, 16'h0,    8'h0,  5'd0};
    vecs[5] = '{{5'd1,  8'h33, 16'h4444, 3'd6}, 0, 0, 32'h0,         1'b0, 3'd0, 16'h0,    8'h0,  5'd0};
    vecs[6] = '{{5'd9,  8'h77, 16'h5555, 3'd7}, 0, 0, 32'h0,         1'b0, 3'd0, 16'h0,    8'h0,  5'd0};

    // Reset with req already high: outputs zero, no command after release.
    reset       = 1'b1;
    instr_i     = {5'd0, 8'd0, 16'h0001, 3'd2};
    act_ins_i   = 2'b01;
    cmd_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'h0;
    for (int i = 0; i < 3; i++) tick();
    check("rst.data",   data_o, 0);
    check("rst.wait",   wait_s_o, 0);
    check("rst.valid",  cmd_valid_o, 0);
    check("rst.err",    err_o, 0);
    check("rst.op",     cmd_op_o, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_req.valid", cmd_valid_o, 0);
    check("rst_req.wait",  wait_s_o, 0);
    check("rst_req.hs",    hs_cnt, 0);
    act_ins_i = 2'b00;
    tick();

    // Table-driven single transactions.
    for (int k = 0; k < 7; k++) do_txn(vecs[k], $sformatf("vec%0d", k));

    // Timeout, then response landing on the expiry cycle.
    do_timeout(1'b0, "tmo");
    do_timeout(1'b1, "tmo_rsp");

    // Abort during WAIT_RSP with req held high, then a late response.
    instr_i   = {5'd0, 8'd0, 16'h0077, 3'd2};
    act_ins_i = 2'b01;
    tick();
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    act_ins_i = 2'b11;
    tick();
    act_ins_i = 2'b01;
    check("abort.wait",  wait_s_o, 0);
    check("abort.data",  data_o, 0);
    check("abort.valid", cmd_valid_o, 0);
    check("abort.err",   err_o, 0);
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h5555_AAAA;
    tick();
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'h0;
    check("abort.late_data", data_o, 0);
    check("abort.late_wait", wait_s_o, 0);
    hs0 = hs_cnt;
    for (int i = 0; i < 6; i++) tick();
    check("abort.held_valid", cmd_valid_o, 0);
    check("abort.held_hs", hs_cnt - hs0, 0);
    act_ins_i = 2'b00;
    tick();
    do_txn(vecs[1], "abort_recover");

    // Reset while a command is pending in ISSUE.
    instr_i   = vecs[0].instr;
    act_ins_i = 2'b01;
    tick();
    check("rst_mid.valid_pre", cmd_valid_o, 1);
    reset     = 1'b1;
    act_ins_i = 2'b00;
    tick();
    check("rst_mid.valid", cmd_valid_o, 0);
    check("rst_mid.wait",  wait_s_o, 0);
    check("rst_mid.data",  data_o, 0);
    check("rst_mid.err",   err_o, 0);
    check("rst_mid.op",    cmd_op_o, 0);
    check("rst_mid.addr",  cmd_addr_o, 0);
    check("rst_mid.wdata", cmd_wdata_o, 0);
    check("rst_mid.param", cmd_param_o, 0);
    reset = 1'b0;
    tick();
    tick();

    // Back-to-back READs with random ready/response delays.
    for (int i = 0; i < 8; i++) begin
      v.instr   = {5'd0, 8'd0, 16'(i * 16'h0111), 3'd2};
      v.rdy_dly = int'($urandom_range(0, 3));
      v.rsp_dly = int'($urandom_range(0, 10));
      v.rsp     = $urandom;
      v.is_cmd  = 1'b1;
      v.op      = 3'd2;
      v.addr    = 16'(i * 16'h0111);
      v.wdata   = 8'd0;
      v.param   = 5'd0;
      do_txn(v, $sformatf("b2b%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
